uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter sitting directly downstream of the cpu write port.
//  Decodes cpu writes to BASE_ADDR and buffers the low byte of wr_data in a FIFO.
//  Serializes each byte onto o_tx as 8N1: one start bit, 8 data bits LSB first, one stop bit.
//  Exposes busy, level and overflow status for the cpu and the bench.
// PARAMETERS
//  BASE_ADDR     32'h10000000  data register address; BASE_ADDR+4 is the control register
//  CLKS_PER_BIT  868           clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  FIFO_AW       4             FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  i_reset_n     in   1          asynchronous, active-low reset
//  wr_valid      in   1          cpu write strobe; one write per high cycle
//  wr_addr       in   32         cpu write address
//  wr_data       in   32         cpu write data; only [7:0] used at BASE_ADDR
//  o_tx          out  1          serial line; idles high
//  o_busy        out  1          high while FIFO is non-empty or a frame is in flight
//  o_fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
//  o_overflow    out  1          sticky; set when a data write is dropped because FIFO is full
// BEHAVIOUR
//  Reset: asserting i_reset_n low takes effect immediately, including mid-frame:
//   o_tx=1, o_busy=0, o_fifo_level=0, o_overflow=0, FSM=IDLE, FIFO pointers and baud/bit counters=0.
//  Decode, sampled at posedge when wr_valid=1:
//   wr_addr==BASE_ADDR: push wr_data[7:0].
//   wr_addr==BASE_ADDR+4: if wr_data[0]=1, clear o_overflow.
//   Any other address: ignored, no side effects.
//  FIFO:
//   Circular buffer with FIFO_AW-bit rd/wr pointers that wrap modulo 2**FIFO_AW.
//   Count is FIFO_AW+1 bits wide.
//   Push when full with no pop in the same cycle: byte dropped, o_overflow<=1.
//   Push and pop in the same cycle: both happen, count unchanged, including when full.
//   Pop only occurs when count>0.
//   Overflow clear and overflow set in the same cycle cannot collide (one write per cycle).
//  FSM states IDLE, START, DATA, STOP. A baud counter reloads to CLKS_PER_BIT-1 on every bit
//  boundary and counts down; a bit ends when the counter reaches 0.
//   IDLE: o_tx=1. If count>0: pop into shift reg, o_tx<=0, go to START.
//   START: hold o_tx=0 for CLKS_PER_BIT cycles, then o_tx<=shift[0], bit_idx<=0, go to DATA.
//   DATA: each bit is held CLKS_PER_BIT cycles. After bit_idx 7 ends, o_tx<=1 and go to STOP.
//   STOP: hold o_tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop, o_tx<=0 and go to
//    START directly with no idle gap; otherwise go to IDLE.
//  Latency: a push accepted at posedge k into an empty, idle block drives o_tx low at posedge k+1.
//  Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
//  o_tx is driven from a register (glitch-free).
//  o_busy = (state!=IDLE) | (count!=0), registered-equivalent.
//  o_fifo_level reflects count after each edge.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_AW=2)
//  Single byte: write 0x10000000 <= 0x000000A5 -> o_tx low 1 cycle after accept edge.
//   Line reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; o_busy falls after 40 cycles.
//  Back-to-back: 3 consecutive writes 0x41,0x42,0x43 -> three contiguous frames, 120 cycles,
//   no idle cycle between stop and next start; level peaks at 2 while frame 1 is sent.
//  Overflow: while frame 0 is in flight, write 5 bytes -> level=4, 5th byte dropped,
//   o_overflow=1. Write 0x10000004 <= 1 -> o_overflow=0. Only 5 frames are emitted.
//  Full + simultaneous pop: push a byte on the exact cycle STOP ends with level=4 ->
//   byte accepted, level stays 4, o_overflow stays 0.
//  Decode: writes to 0x10000008 and 0x00000000 -> no push, o_tx stays 1, level stays 0.
//  Reset mid-frame: drop i_reset_n during DATA bit 3 -> o_tx=1 and level=0 asynchronously.
//   After release, a new write 0x5A produces a clean, full frame.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_mmio_if : cpu write-port bundle feeding the memory-mapped UART TX.
// Revision 1.0
// ---------------------------------------------------------------------------
interface uart_tx_mmio_if;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_mmio : cpu-mapped byte FIFO feeding an 8N1 serial transmitter.
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  wire logic         clk,
  input  wire logic         i_reset_n,
  uart_tx_mmio_if.slave     bus,
  output logic              o_tx,
  output logic              o_busy,
  output logic [FIFO_AW:0]  o_fifo_level,
  output logic              o_overflow
);

  localparam int unsigned                c_depth       = 2**FIFO_AW;
  localparam int unsigned                c_baud_w      = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0]        c_baud_reload = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]           c_full_count  = (FIFO_AW+1)'(c_depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [c_baud_w-1:0]   baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            mem_q [c_depth];

  logic push_req, ctrl_clr, full, push, pop, bit_done, count_nz;
  logic unused_data_bits;

  assign unused_data_bits = ^bus.wr_data[31:8];

  assign push_req = bus.wr_valid && (bus.wr_addr == BASE_ADDR);
  assign ctrl_clr = bus.wr_valid && (bus.wr_addr == BASE_ADDR + 32'd4) && bus.wr_data[0];
  assign full     = (count_q == c_full_count);
  assign count_nz = (count_q != '0);
  assign bit_done = (baud_q == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_nz) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = c_baud_reload;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          baud_d    = c_baud_reload;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - c_baud_w'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d = c_baud_reload;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - c_baud_w'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (count_nz) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            baud_d  = c_baud_reload;
            state_d = START;
          end else begin
            baud_d  = '0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - c_baud_w'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d    = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    overflow_d = overflow_q;
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end else if (ctrl_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data[7:0];
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != IDLE) || count_nz;
  assign o_fifo_level = count_q;
  assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_mmio : directed self-checking bench for uart_tx_mmio (4 clk/bit, depth 4).
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_mmio;

  logic       clk;
  logic       rst_n;
  logic       tx;
  logic       busy;
  logic [2:0] level;
  logic       ovf;
  int         tests;
  int         fails;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR    (32'h1000_0000),
    .CLKS_PER_BIT (4),
    .FIFO_AW      (2)
  ) dut (
    .clk          (clk),
    .i_reset_n    (rst_n),
    .bus          (bus),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_fifo_level (level),
    .o_overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one write for exactly one posedge; returns on the following negedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at frame position 'start' (position 0 = first negedge with the start bit on the line).
  task automatic expect_frame(input string tag, input logic [7:0] b, input int start);
    logic       e;
    logic [3:0] seen;
    for (int bi = start / 4; bi < 10; bi++) begin
      e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      for (int j = 0; j < 4; j++) begin
        if (bi * 4 + j >= start) begin
          seen[j] = tx;
          @(negedge clk);
        end else begin
          seen[j] = e;
        end
      end
      check($sformatf("%s_bit%0d", tag, bi), {28'd0, seen}, {28'd0, {4{e}}});
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
    check(tag, lows, 0);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    skip(2);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    skip(2);

    // Single byte 0xA5
    wr(32'h1000_0000, 32'h0000_00A5);
    check("a5_accept_level", level, 1);
    check("a5_accept_tx", tx, 1);
    check("a5_accept_busy", busy, 1);
    @(negedge clk);
    check("a5_latency_tx", tx, 0);
    check("a5_pop_level", level, 0);
    expect_frame("a5", 8'hA5, 0);
    check("a5_done_busy", busy, 0);
    check("a5_done_tx", tx, 1);
    skip(3);

    // Back-to-back 0x41, 0x42, 0x43
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 32'h1000_0000;
    bus.wr_data  = 32'h41;
    @(negedge clk);
    bus.wr_data  = 32'h42;
    check("b2b_level_a", level, 1);
    @(negedge clk);
    bus.wr_data  = 32'h43;
    check("b2b_level_b", level, 1);
    check("b2b_p0_tx", tx, 0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check("b2b_level_peak", level, 2);
    expect_frame("b2b_41", 8'h41, 1);
    expect_frame("b2b_42", 8'h42, 0);
    expect_frame("b2b_43", 8'h43, 0);
    check("b2b_done_busy", busy, 0);
    skip(3);

    // Overflow: 5 writes while frame 0 is in flight
    wr(32'h1000_0000, 32'h11);
    wr(32'h1000_0000, 32'h21);
    wr(32'h1000_0000, 32'h22);
    wr(32'h1000_0000, 32'h23);
    wr(32'h1000_0000, 32'h24);
    wr(32'h1000_0000, 32'h25);
    check("ovf_level", level, 4);
    check("ovf_set", ovf, 1);
    wr(32'h1000_0004, 32'h0);
    check("ovf_keep_on_zero", ovf, 1);
    wr(32'h1000_0004, 32'h1);
    check("ovf_clear", ovf, 0);
    expect_frame("ovf_11", 8'h11, 6);
    expect_frame("ovf_21", 8'h21, 0);
    expect_frame("ovf_22", 8'h22, 0);
    expect_frame("ovf_23", 8'h23, 0);
    expect_frame("ovf_24", 8'h24, 0);
    check("ovf_done_busy", busy, 0);
    expect_quiet("ovf_no_sixth_frame", 50);

    // Full FIFO with a push on the exact edge the STOP bit ends
    wr(32'h1000_0000, 32'h31);
    wr(32'h1000_0000, 32'h32);
    wr(32'h1000_0000, 32'h33);
    wr(32'h1000_0000, 32'h34);
    wr(32'h1000_0000, 32'h35);
    check("full_level", level, 4);
    skip(36);
    check("full_pre_level", level, 4);
    wr(32'h1000_0000, 32'h36);
    check("full_pop_push_level", level, 4);
    check("full_pop_push_ovf", ovf, 0);
    check("full_next_start", tx, 0);
    expect_frame("full_32", 8'h32, 0);
    expect_frame("full_33", 8'h33, 0);
    expect_frame("full_34", 8'h34, 0);
    expect_frame("full_35", 8'h35, 0);
    expect_frame("full_36", 8'h36, 0);
    check("full_done_busy", busy, 0);

    // Address decode
    wr(32'h1000_0008, 32'h77);
    wr(32'h0000_0000, 32'h77);
    check("dec_level", level, 0);
    check("dec_busy", busy, 0);
    check("dec_ovf", ovf, 0);
    expect_quiet("dec_quiet", 12);

    // Asynchronous reset during DATA bit 3 (0xA5 bit 3 is 0)
    wr(32'h1000_0000, 32'hA5);
    wr(32'h1000_0000, 32'h77);
    skip(17);
    check("mid_bit3_tx", tx, 0);
    check("mid_level", level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("mid_post_quiet", 8);
    wr(32'h1000_0000, 32'h5A);
    @(negedge clk);
    check("mid_5a_start", tx, 0);
    expect_frame("mid_5a", 8'h5A, 0);
    check("mid_done_busy", busy, 0);
    check("mid_done_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
